// File: rtl/mbist_wb_mem_tester.sv
// Wishbone initiator for functional SRAM sanity checks: fills an address range with a
// pattern and/or reads it back, counting mismatches and bus errors.
module mbist_wb_mem_tester #(
    parameter int unsigned BIST_ADDR_WD = 10,
    parameter int unsigned BIST_DATA_WD = 32,
    parameter int unsigned TIMEOUT_WD   = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_abort,
    input  logic [1:0]                cfg_mode,
    input  logic                      cfg_addr_xor,
    input  logic [BIST_DATA_WD-1:0]   cfg_pattern,
    input  logic [BIST_ADDR_WD-1:0]   cfg_start_addr,
    input  logic [BIST_ADDR_WD-1:0]   cfg_end_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic                      timeout,
    output logic                      aborted,
    output logic [15:0]               err_cnt,
    output logic [BIST_ADDR_WD-1:0]   first_err_addr,
    output logic [BIST_DATA_WD-1:0]   first_err_data,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [BIST_ADDR_WD-1:0]   wb_adr_o,
    output logic [BIST_DATA_WD-1:0]   wb_dat_o,
    output logic [BIST_DATA_WD/8-1:0] wb_sel_o,
    input  logic [BIST_DATA_WD-1:0]   wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN} state_t;

    // Timeout fires on the cycle the counter would reach all-ones.
    localparam logic [TIMEOUT_WD-1:0] TMO_LAST = {{(TIMEOUT_WD-1){1'b1}}, 1'b0};

    state_t                    state_q, state_d;
    logic [BIST_ADDR_WD-1:0]   addr_q, addr_d;
    logic [BIST_ADDR_WD-1:0]   start_q, start_d;
    logic [BIST_ADDR_WD-1:0]   end_q, end_d;
    logic [BIST_DATA_WD-1:0]   pattern_q, pattern_d;
    logic                      xor_q, xor_d;
    logic                      check_q, check_d;
    logic [TIMEOUT_WD-1:0]     tmo_q, tmo_d;
    logic [15:0]               err_cnt_q, err_cnt_d;
    logic [BIST_ADDR_WD-1:0]   ferr_addr_q, ferr_addr_d;
    logic [BIST_DATA_WD-1:0]   ferr_data_q, ferr_data_d;
    logic                      timeout_q, timeout_d;
    logic                      aborted_q, aborted_d;

    logic                      rec;
    logic [BIST_DATA_WD-1:0]   rec_data;
    logic [BIST_DATA_WD-1:0]   expected;
    logic                      in_req;
    logic                      in_run;

    assign expected = cfg_pattern_sel();
    function automatic logic [BIST_DATA_WD-1:0] cfg_pattern_sel();
        return xor_q ? (pattern_q ^ BIST_DATA_WD'(addr_q)) : pattern_q;
    endfunction

    assign in_req = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign in_run = in_req || (state_q == WR_GAP) || (state_q == RD_GAP);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        start_d     = start_q;
        end_d       = end_q;
        pattern_d   = pattern_q;
        xor_d       = xor_q;
        check_d     = check_q;
        tmo_d       = '0;
        err_cnt_d   = err_cnt_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        rec         = 1'b0;
        rec_data    = '0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    err_cnt_d   = '0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    timeout_d   = 1'b0;
                    aborted_d   = 1'b0;
                    addr_d      = cfg_start_addr;
                    start_d     = cfg_start_addr;
                    end_d       = cfg_end_addr;
                    pattern_d   = cfg_pattern;
                    xor_d       = cfg_addr_xor;
                    check_d     = (cfg_mode != 2'd0);
                    if (cfg_end_addr < cfg_start_addr) state_d = FIN;
                    else if (cfg_mode == 2'd1)         state_d = RD_REQ;
                    else                               state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (wb_err_i) begin
                    rec     = 1'b1;
                    state_d = WR_GAP;
                end else if (wb_ack_i) begin
                    state_d = WR_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_WD'(1);
                end
            end
            WR_GAP: begin
                if (addr_q == end_q) begin
                    if (check_q) begin
                        addr_d  = start_q;
                        state_d = RD_REQ;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    addr_d  = addr_q + BIST_ADDR_WD'(1);
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                if (wb_err_i) begin
                    rec     = 1'b1;
                    state_d = RD_GAP;
                end else if (wb_ack_i) begin
                    rec      = (wb_dat_i != expected);
                    rec_data = wb_dat_i;
                    state_d  = RD_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_WD'(1);
                end
            end
            RD_GAP: begin
                if (addr_q == end_q) begin
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + BIST_ADDR_WD'(1);
                    state_d = RD_REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rec) begin
            if (err_cnt_q == '0) begin
                ferr_addr_d = addr_q;
                ferr_data_d = rec_data;
            end
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
        end

        // Abort overrides the next state but a response in the same cycle is already scored.
        if (in_run && cfg_abort) begin
            aborted_d = 1'b1;
            state_d   = FIN;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            pattern_q   <= '0;
            xor_q       <= 1'b0;
            check_q     <= 1'b0;
            tmo_q       <= '0;
            err_cnt_q   <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            start_q     <= start_d;
            end_q       <= end_d;
            pattern_q   <= pattern_d;
            xor_q       <= xor_d;
            check_q     <= check_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
        end
    end

    assign busy           = in_run;
    assign done           = (state_q == FIN);
    assign fail           = (err_cnt_q != '0) || timeout_q;
    assign timeout        = timeout_q;
    assign aborted        = aborted_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
    assign wb_cyc_o       = in_req;
    assign wb_stb_o       = in_req;
    assign wb_we_o        = (state_q == WR_REQ);
    assign wb_adr_o       = in_req ? addr_q : '0;
    assign wb_dat_o       = (state_q == WR_REQ) ? expected : '0;
    assign wb_sel_o       = in_req ? '1 : '0;

endmodule

// File: tb/tb_mbist_wb_mem_tester.sv
// Bench for mbist_wb_mem_tester: wrapper/SRAM responder plus a range-level reference model.
module tb_mbist_wb_mem_tester;

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_addr_xor = 1'b0;
    logic [31:0] cfg_pattern = '0;
    logic [9:0]  cfg_start_addr = '0;
    logic [9:0]  cfg_end_addr = '0;
    logic        busy, done, fail, timeout, aborted;
    logic [15:0] err_cnt;
    logic [9:0]  first_err_addr;
    logic [31:0] first_err_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [9:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    mbist_wb_mem_tester #(.BIST_ADDR_WD(10), .BIST_DATA_WD(32), .TIMEOUT_WD(4)) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_mode(cfg_mode), .cfg_addr_xor(cfg_addr_xor), .cfg_pattern(cfg_pattern),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .busy(busy), .done(done), .fail(fail), .timeout(timeout), .aborted(aborted),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Responder knobs, driven only by the stimulus block.
    logic        hang = 1'b0;
    logic        err_en = 1'b0;
    logic [9:0]  err_addr = '0;
    logic [9:0]  fault_addr = '0;
    logic [31:0] fault_mask = '0;
    logic [31:0] mem_seed = '0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        rd_ack_q;
    logic [31:0] rd_dat;

    function automatic logic [31:0] memf(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ mem_seed;
    endfunction

    // Wrapper behaviour: writes acked with stb, reads acked one cycle later.
    assign wb_ack_i = wb_cyc_o & wb_stb_o & ~hang & (wb_we_o | rd_ack_q);
    assign wb_err_i = wb_ack_i & err_en & (wb_adr_o == err_addr);
    assign wb_dat_i = rd_dat;

    always @(posedge wb_clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= memf(i);
            rd_ack_q <= 1'b0;
            rd_dat   <= '0;
        end else begin
            if (wb_ack_i && !wb_err_i && wb_we_o) mem[wb_adr_o] <= wb_dat_o;
            if (wb_cyc_o && wb_stb_o && !wb_we_o && !rd_ack_q && !hang) begin
                rd_ack_q <= 1'b1;
                rd_dat   <= mem[wb_adr_o] ^ ((wb_adr_o == fault_addr) ? fault_mask : 32'h0);
            end else begin
                rd_ack_q <= 1'b0;
                rd_dat   <= '0;
            end
        end
    end

    // Bus monitor, sampled mid-cycle; counters are cumulative.
    int nw = 0, nr = 0, nstb = 0, viol = 0, ndone = 0;
    logic prev_wait = 1'b0, gap_due = 1'b0, p_we = 1'b0;
    logic [9:0]  p_adr = '0;
    logic [31:0] p_dat = '0;
    always @(negedge wb_clk_i) begin
        if (wb_stb_o) begin
            nstb++;
            if (!wb_cyc_o || wb_sel_o !== 4'hF || gap_due) viol++;
            if (prev_wait && (wb_adr_o !== p_adr || wb_we_o !== p_we || wb_dat_o !== p_dat)) viol++;
            if (wb_ack_i || wb_err_i) begin
                if (wb_we_o) nw++;
                else         nr++;
            end
        end
        if (done) ndone++;
        gap_due   = wb_stb_o && (wb_ack_i || wb_err_i);
        prev_wait = wb_stb_o && !(wb_ack_i || wb_err_i);
        p_adr     = wb_adr_o;
        p_we      = wb_we_o;
        p_dat     = wb_dat_o;
    end

    int n_cmp = 0, n_bad = 0;
    int b_nw, b_nr, b_nstb, b_viol, b_ndone;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] expw(input bit x, input logic [31:0] p, input int a);
        return x ? (p ^ 32'(a)) : p;
    endfunction

    // Whole-range model: all fills, then all checks, scored against ref_mem.
    task automatic model_run(input logic [1:0] m, input bit x, input logic [31:0] p,
                             input logic [9:0] s, input logic [9:0] e,
                             output int cyc, output int cnt, output logic [9:0] fa,
                             output logic [31:0] fd, output int nwr, output int nrd);
        int n;
        bit fl, ck;
        logic [31:0] rd;
        fl = (m != 2'd1);
        ck = (m != 2'd0);
        n = (e >= s) ? (int'(e) - int'(s) + 1) : 0;
        cnt = 0; fa = '0; fd = '0;
        nwr = fl ? n : 0;
        nrd = ck ? n : 0;
        cyc = n * ((fl ? 2 : 0) + (ck ? 3 : 0)) + 1;
        if (n > 0 && fl) for (int a = int'(s); a <= int'(e); a++) begin
            if (err_en && a == int'(err_addr)) begin
                if (cnt == 0) begin fa = 10'(a); fd = '0; end
                cnt++;
            end else ref_mem[a] = expw(x, p, a);
        end
        if (n > 0 && ck) for (int a = int'(s); a <= int'(e); a++) begin
            rd = ref_mem[a] ^ ((a == int'(fault_addr)) ? fault_mask : 32'h0);
            if (err_en && a == int'(err_addr)) begin
                if (cnt == 0) begin fa = 10'(a); fd = '0; end
                cnt++;
            end else if (rd != expw(x, p, a)) begin
                if (cnt == 0) begin fa = 10'(a); fd = rd; end
                cnt++;
            end
        end
    endtask

    // Pulse start for one cycle; returns one time unit into the first busy cycle.
    task automatic start_run(input logic [1:0] m, input bit x, input logic [31:0] p,
                             input logic [9:0] s, input logic [9:0] e);
        @(posedge wb_clk_i); #2;
        cfg_mode = m; cfg_addr_xor = x; cfg_pattern = p;
        cfg_start_addr = s; cfg_end_addr = e; cfg_start = 1'b1;
        b_nw = nw; b_nr = nr; b_nstb = nstb; b_viol = viol; b_ndone = ndone;
        @(posedge wb_clk_i); #1;
        cfg_start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [1:0] m, input bit x,
                             input logic [31:0] p, input logic [9:0] s, input logic [9:0] e);
        int ecyc, ecnt, enw, enr, cyc, diff;
        logic [9:0]  efa;
        logic [31:0] efd;
        model_run(m, x, p, s, e, ecyc, ecnt, efa, efd, enw, enr);
        start_run(m, x, p, s, e);
        cyc = 1;
        check({tag, "_busy1"}, busy, e >= s);
        while (!done && cyc < 400) begin
            @(posedge wb_clk_i); #1;
            cyc++;
        end
        check({tag, "_cycles"}, cyc, ecyc);
        check({tag, "_errcnt"}, err_cnt, ecnt);
        check({tag, "_ferr"}, {first_err_addr, first_err_data}, {efa, efd});
        check({tag, "_flags"}, {fail, timeout, aborted}, {ecnt != 0, 1'b0, 1'b0});
        @(posedge wb_clk_i); #1;
        check({tag, "_after"}, {busy, done, wb_stb_o}, 3'b000);
        check({tag, "_bus"}, {32'(nw - b_nw), 32'(nr - b_nr)}, {32'(enw), 32'(enr)});
        check({tag, "_stb"}, nstb - b_nstb, enw + 2 * enr);
        check({tag, "_proto"}, {32'(viol - b_viol), 32'(ndone - b_ndone)}, {32'd0, 32'd1});
        diff = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
        check({tag, "_mem"}, diff, 0);
    endtask

    initial begin
        int cyc, len;
        logic [9:0]  s, e;
        logic [31:0] p;

        mem_seed = $urandom;
        for (int i = 0; i < 1024; i++) ref_mem[i] = memf(i);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_ctrl", {busy, done, fail, timeout, aborted, wb_cyc_o, wb_stb_o, wb_we_o}, '0);
        check("rst_res", {err_cnt, first_err_addr, first_err_data}, '0);
        check("rst_bus", {wb_adr_o, wb_dat_o, wb_sel_o}, '0);
        @(negedge wb_clk_i) rst_n = 1'b1;

        run_check("fill_chk", 2'd2, 1'b0, 32'hA5A5_5A5A, 10'h010, 10'h013);

        fault_addr = 10'h012; fault_mask = 32'h8;
        run_check("fault", 2'd2, 1'b1, 32'h1234_5678, 10'h010, 10'h013);
        check("fault_data", first_err_data, (32'h1234_5678 ^ 32'h12) ^ 32'h8);
        fault_mask = '0;

        run_check("top_end", 2'd2, 1'b1, 32'hCAFE_F00D, 10'h3FE, 10'h3FF);
        run_check("empty", 2'd2, 1'b0, 32'h0F0F_0F0F, 10'h021, 10'h020);

        // Target that never responds; a start pulse mid-run must be ignored.
        hang = 1'b1;
        start_run(2'd2, 1'b0, 32'h5555_AAAA, 10'h040, 10'h047);
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 5) begin #1; cfg_start = 1'b1; end
            @(posedge wb_clk_i); #1;
            cfg_start = 1'b0;
            cyc++;
        end
        check("tmo_cycles", cyc, 16);
        check("tmo_stb", nstb - b_nstb, 15);
        check("tmo_flags", {fail, timeout, aborted, err_cnt}, {3'b110, 16'd0});
        @(posedge wb_clk_i); #1;
        check("tmo_after", {busy, done, wb_stb_o}, 3'b000);
        hang = 1'b0;

        // Abort during the third read of an 8-word check.
        run_check("pre_fill", 2'd0, 1'b0, 32'h3C3C_C3C3, 10'h080, 10'h087);
        start_run(2'd1, 1'b0, 32'h3C3C_C3C3, 10'h080, 10'h087);
        repeat (6) begin @(posedge wb_clk_i); #1; end
        check("abt_req", {wb_stb_o, wb_we_o, wb_adr_o}, {2'b10, 10'h082});
        #1 cfg_abort = 1'b1;
        @(posedge wb_clk_i); #1;
        cfg_abort = 1'b0;
        check("abt_state", {wb_stb_o, wb_cyc_o, done, busy, aborted, fail}, 6'b001010);
        check("abt_reads", {32'(nr - b_nr), 16'(err_cnt)}, {32'd2, 16'd0});
        run_check("post_abt", 2'd1, 1'b0, 32'h3C3C_C3C3, 10'h080, 10'h087);

        for (int i = 0; i < 12; i++) begin
            s   = 10'($urandom_range(1, 1023));
            len = $urandom_range(0, 8);
            if (len == 0) e = s - 10'd1;
            else e = (int'(s) + len - 1 > 1023) ? 10'h3FF : 10'(int'(s) + len - 1);
            p = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                fault_addr = s + 10'($urandom_range(0, 7));
                fault_mask = 32'd1 << $urandom_range(0, 31);
            end
            err_en   = ($urandom_range(0, 3) == 0);
            err_addr = s + 10'($urandom_range(0, 3));
            run_check($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      p, s, e);
            fault_mask = '0;
            err_en     = 1'b0;
        end

        // Asynchronous reset in the middle of a run.
        start_run(2'd1, 1'b0, 32'hFFFF_0000, 10'h100, 10'h107);
        repeat (4) @(posedge wb_clk_i);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_ctrl", {busy, done, fail, timeout, aborted, wb_cyc_o, wb_stb_o, wb_we_o}, '0);
        check("mrst_res", {err_cnt, first_err_addr, first_err_data, wb_adr_o, wb_dat_o, wb_sel_o}, '0);
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i) rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
